// File: rtl/sr_pkg.sv
// Shared definitions for the PISO/SIPO shift stages: state encodings and default word width.
package sr_pkg;

  localparam int unsigned SR_WIDTH = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } in_state_e;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

  // Bit-counter width for a given word width; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/sipo_deser_if.sv
// Serial input, parallel valid/ready output and status signals of the SIPO deserializer.
interface sipo_deser_if
  import sr_pkg::*;
#(
  parameter int unsigned WIDTH = SR_WIDTH
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  logic             se_in;
  logic             se_en;
  logic             sync;
  logic [WIDTH-1:0] pa_out;
  logic             pa_valid;
  logic             pa_ready;
  logic [CNT_W-1:0] bit_cnt;
  logic             ovf;
  logic             clr_ovf;

  // Producer of serial bits and consumer of parallel words.
  modport master (
    output se_in, se_en, sync, pa_ready, clr_ovf,
    input  pa_out, pa_valid, bit_cnt, ovf
  );

  // The deserializer itself.
  modport slave (
    input  se_in, se_en, sync, pa_ready, clr_ovf,
    output pa_out, pa_valid, bit_cnt, ovf
  );

endinterface

// File: rtl/word_hold_reg.sv
// One-entry valid/ready holding register; a word arriving while full and not drained
// is dropped and recorded in a sticky overflow flag.
module word_hold_reg
  import sr_pkg::*;
#(
  parameter int unsigned WIDTH = SR_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             out_ready,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             ovf
);

  out_state_e       state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             ovf_q, ovf_d;
  logic             drop_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
    end
  end

  // Load/drain/drop decisions; a same-edge drop overrides clr_ovf.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    drop_c  = 1'b0;
    ovf_d   = clr_ovf ? 1'b0 : ovf_q;

    case (state_q)
      EMPTY: begin
        if (in_valid) begin
          data_d  = in_data;
          state_d = FULL;
        end
      end
      FULL: begin
        if (in_valid) begin
          if (out_ready) begin
            data_d = in_data;
          end else begin
            drop_c = 1'b1;
          end
        end else if (out_ready) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase

    if (drop_c) begin
      ovf_d = 1'b1;
    end
  end

  assign out_data  = data_q;
  assign out_valid = (state_q == FULL);
  assign ovf       = ovf_q;

endmodule

// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserializer: LSB-first shift register and bit counter feeding
// a one-entry holding register.
module sipo_deser
  import sr_pkg::*;
#(
  parameter int unsigned WIDTH = SR_WIDTH
) (
  input  logic        clk,
  input  logic        rst,
  sipo_deser_if.slave bus
);

  localparam int unsigned      CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  in_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] word_c;
  logic             word_done_c;

  logic [WIDTH-1:0] hold_data;
  logic             hold_valid;
  logic             hold_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
    end
  end

  // Input FSM: every enabled bit shifts in; sync restarts the word with this bit as bit 0.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    word_done_c = 1'b0;
    word_c      = {bus.se_in, sh_q[WIDTH-1:1]};

    if (bus.se_en) begin
      sh_d = word_c;
      case (state_q)
        IDLE: begin
          cnt_d   = CNT_ONE;
          state_d = SHIFT;
        end
        SHIFT: begin
          if (bus.sync) begin
            cnt_d = CNT_ONE;
          end else if (cnt_q == CNT_LAST) begin
            cnt_d       = '0;
            state_d     = IDLE;
            word_done_c = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      endcase
    end
  end

  word_hold_reg #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (word_done_c),
    .in_data   (word_c),
    .out_ready (bus.pa_ready),
    .clr_ovf   (bus.clr_ovf),
    .out_data  (hold_data),
    .out_valid (hold_valid),
    .ovf       (hold_ovf)
  );

  assign bus.pa_out   = hold_data;
  assign bus.pa_valid = hold_valid;
  assign bus.ovf      = hold_ovf;
  assign bus.bit_cnt  = cnt_q;

endmodule

// File: tb/tb_sipo_deser.sv
// Directed and randomized checks of sipo_deser against a queue-based word-assembly model.
module tb_sipo_deser;

  localparam int unsigned W = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  sipo_deser_if #(.WIDTH(W)) bus ();

  sipo_deser #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Reference model: bits of the partial word in arrival order, plus the held word.
  bit         part_q[$];
  logic [W-1:0] m_out;
  bit         m_valid;
  bit         m_ovf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("pa_valid", 32'(bus.pa_valid), 32'(m_valid));
    chk("pa_out",   32'(bus.pa_out),   32'(m_out));
    chk("bit_cnt",  32'(bus.bit_cnt),  32'(part_q.size()));
    chk("ovf",      32'(bus.ovf),      32'(m_ovf));
  endtask

  task automatic model_reset();
    part_q.delete();
    m_out   = '0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
  endtask

  task automatic model_edge(input bit in, input bit en, input bit syn, input bit rdy, input bit clr);
    bit           done = 1'b0;
    bit           drop = 1'b0;
    logic [W-1:0] word = '0;
    if (en) begin
      if (syn) part_q.delete();
      part_q.push_back(in);
      if (part_q.size() == W) begin
        for (int i = 0; i < W; i++) word[i] = part_q[i];
        part_q.delete();
        done = 1'b1;
      end
    end
    if (done) begin
      if (!m_valid || rdy) begin
        m_out   = word;
        m_valid = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    if (clr)  m_ovf = 1'b0;
    if (drop) m_ovf = 1'b1;
  endtask

  task automatic step(input bit in, input bit en, input bit syn, input bit rdy, input bit clr);
    @(negedge clk);
    bus.se_in    = in;
    bus.se_en    = en;
    bus.sync     = syn;
    bus.pa_ready = rdy;
    bus.clr_ovf  = clr;
    model_edge(in, en, syn, rdy, clr);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic send(input logic [W-1:0] w, input bit rdy);
    for (int i = 0; i < W; i++) step(w[i], 1'b1, 1'b0, rdy, 1'b0);
  endtask

  // Asynchronous reset pulse away from the clock edge.
  task automatic pulse_reset();
    @(negedge clk);
    bus.se_en    = 1'b0;
    bus.sync     = 1'b0;
    bus.pa_ready = 1'b0;
    bus.clr_ovf  = 1'b0;
    rst = 1'b1;
    model_reset();
    #2;
    check_all();
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    bus.se_in    = 1'b0;
    bus.se_en    = 1'b0;
    bus.sync     = 1'b0;
    bus.pa_ready = 1'b0;
    bus.clr_ovf  = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // Fill the holder, force a drop, leave a partial word, then reset mid-word.
    send(4'h3, 1'b0);
    send(4'hC, 1'b0);
    chk("pre_rst_ovf", 32'(bus.ovf), 32'd1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse_reset();
    chk("rst_bit_cnt", 32'(bus.bit_cnt), 32'd0);
    chk("rst_pa_out", 32'(bus.pa_out), 32'd0);
    send(4'h6, 1'b0);
    chk("clean_word", 32'(bus.pa_out), 32'h6);

    // Consume the held word while a new 1010 arrives; valid lasts one cycle.
    send(4'b1010, 1'b1);
    chk("w1010_out", 32'(bus.pa_out), 32'b1010);
    chk("w1010_valid", 32'(bus.pa_valid), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("w1010_drop", 32'(bus.pa_valid), 32'd0);

    // Gapped enables, including an ignored sync during a gap.
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("gap_cnt", 32'(bus.bit_cnt), 32'd2);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("gap_word", 32'(bus.pa_out), 32'b0011);

    // Back-pressure: A held, 5 dropped, drain, clear.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send(4'hA, 1'b0);
    send(4'h5, 1'b0);
    chk("bp_out", 32'(bus.pa_out), 32'hA);
    chk("bp_ovf", 32'(bus.ovf), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("bp_drain", 32'(bus.pa_valid), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("bp_clr", 32'(bus.ovf), 32'd0);

    // Sync restarts the word mid-way.
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("sync_cnt", 32'(bus.bit_cnt), 32'd1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("sync_word", 32'(bus.pa_out), 32'b1001);

    // Back-to-back: ready only at the completing edge replaces the held word.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("b2b_out", 32'(bus.pa_out), 32'b0110);
    chk("b2b_valid", 32'(bus.pa_valid), 32'd1);
    chk("b2b_ovf", 32'(bus.ovf), 32'd0);

    // Drop and clear at the same edge: the drop wins.
    for (int i = 0; i < W - 1; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("set_wins", 32'(bus.ovf), 32'd1);
    chk("set_wins_out", 32'(bus.pa_out), 32'b0110);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        pulse_reset();
      end else begin
        step(1'($urandom_range(0, 1)),
             $urandom_range(0, 9) < 7,
             $urandom_range(0, 9) == 0,
             1'($urandom_range(0, 1)),
             $urandom_range(0, 19) == 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
